// File: rtl/stopwatch_pkg.sv
// Shared constants for the four-digit BCD stopwatch: digit geometry,
// run-control state encoding and the single-digit BCD successor.
package stopwatch_pkg;

    localparam int BCD_W    = 4;
    localparam int N_DIGITS = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // 2'd3 is unused and falls back to ST_IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Out-of-range codes also return to 0 so a corrupted digit self-heals.
    function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] q);
        if (q >= BCD_MAX) return '0;
        return q + 1'b1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the stopwatch: increments on inc, rolls 9 -> 0 and
// emits a carry into the next more significant digit.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry_out
);

    always_ff @(posedge CLOCK_50) begin
        if (RESET || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= bcd_next(q);
        end
    end

    assign carry_out = inc & (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch: button conditioning, IDLE/RUN/PAUSE control,
// tick prescaler and a chained bcd_digit cascade with a rollover pulse.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             start_stop,
    input  logic             clear,
    output logic [BCD_W-1:0] dig0,
    output logic [BCD_W-1:0] dig1,
    output logic [BCD_W-1:0] dig2,
    output logic [BCD_W-1:0] dig3,
    output logic             running,
    output logic             wrap,
    output logic [1:0]       state_dbg
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("bcd_stopwatch: CLK_HZ/TICK_HZ must be at least 2");
    end

    // [0],[1] synchronize the async button, [2] is the previous synced value.
    logic [2:0] ss_sh;
    logic [2:0] clr_sh;
    logic       ss_evt;
    logic       clr_evt;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            ss_sh  <= '0;
            clr_sh <= '0;
        end else begin
            ss_sh  <= {ss_sh[1:0], start_stop};
            clr_sh <= {clr_sh[1:0], clear};
        end
    end

    assign ss_evt  = ss_sh[1] & ~ss_sh[2];
    assign clr_evt = clr_sh[1] & ~clr_sh[2];

    logic [1:0] state_r;
    logic [1:0] state_nxt;

    always_comb begin
        state_nxt = state_r;
        if (clr_evt) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  if (ss_evt) state_nxt = ST_RUN;
                ST_RUN:   if (ss_evt) state_nxt = ST_PAUSE;
                ST_PAUSE: if (ss_evt) state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    assign running   = (state_r == ST_RUN);
    assign state_dbg = state_r;

    // Digits and prescaler are held at zero outside RUN/PAUSE, and zeroed on clear.
    logic          hold_zero;
    logic [PW-1:0] presc;
    logic          tick;

    assign hold_zero = clr_evt | ((state_r != ST_RUN) && (state_r != ST_PAUSE));
    assign tick      = running && (presc == PRESC_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (RESET || hold_zero) begin
            presc <= '0;
        end else if (running) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    logic [BCD_W-1:0]    q     [N_DIGITS];
    logic [N_DIGITS-1:0] carry;
    logic [N_DIGITS-1:0] inc;

    assign inc = {carry[N_DIGITS-2:0], tick};

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
        bcd_digit u_dig (
            .CLOCK_50  (CLOCK_50),
            .RESET     (RESET),
            .clr       (hold_zero),
            .inc       (inc[i]),
            .q         (q[i]),
            .carry_out (carry[i])
        );
    end

    assign dig0 = q[0];
    assign dig1 = q[1];
    assign dig2 = q[2];
    assign dig3 = q[3];

    // Registered so the pulse coincides with the cycle the display shows 0000.
    always_ff @(posedge CLOCK_50) begin
        if (RESET || hold_zero) begin
            wrap <= 1'b0;
        end else begin
            wrap <= &carry;
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: a DIV=10 instance for control and
// counting scenarios, a DIV=2 instance to reach the 9999 rollover quickly.
module tb_bcd_stopwatch;

    localparam int DIV = 10;

    logic CLOCK_50 = 1'b0;
    logic RESET, start_stop, clear;
    logic rst_w, ss_w, clr_w;

    logic [3:0] dig0, dig1, dig2, dig3;
    logic       running, wrap;
    logic [1:0] state_dbg;
    logic [3:0] dig0_w, dig1_w, dig2_w, dig3_w;
    logic       running_w, wrap_w;
    logic [1:0] state_dbg_w;

    logic [15:0] digs, digs_w;
    assign digs   = {dig3, dig2, dig1, dig0};
    assign digs_w = {dig3_w, dig2_w, dig1_w, dig0_w};

    logic [15:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    logic inv_en = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_stopwatch #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .start_stop (start_stop),
        .clear      (clear),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .running    (running),
        .wrap       (wrap),
        .state_dbg  (state_dbg)
    );

    bcd_stopwatch #(.CLK_HZ(2), .TICK_HZ(1)) dut_w (
        .CLOCK_50   (CLOCK_50),
        .RESET      (rst_w),
        .start_stop (ss_w),
        .clear      (clr_w),
        .dig0       (dig0_w),
        .dig1       (dig1_w),
        .dig2       (dig2_w),
        .dig3       (dig3_w),
        .running    (running_w),
        .wrap       (wrap_w),
        .state_dbg  (state_dbg_w)
    );

    // Digit range invariant on both instances, sampled on the inactive edge.
    always @(negedge CLOCK_50) begin
        if (inv_en) begin
            total++;
            if (!(dig0 <= 4'd9 && dig1 <= 4'd9 && dig2 <= 4'd9 && dig3 <= 4'd9 &&
                  dig0_w <= 4'd9 && dig1_w <= 4'd9 && dig2_w <= 4'd9 && dig3_w <= 4'd9)) begin
                bad++;
                $display("FAIL digit_range: got %h / %h, required every digit <= 9", digs, digs_w);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] bcd_inc(input logic [15:0] b);
        int v;
        v = b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
        v = (v + 1) % 10000;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // n = edges until the main instance's digits change, -1 on timeout.
    task automatic wait_change(input int budget, output int n);
        logic [15:0] prev;
        prev = digs;
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (digs !== prev) return;
        end
        n = -1;
    endtask

    logic [15:0] model_digs;

    task automatic test_reset();
        RESET = 1'b1; start_stop = 1'b0; clear = 1'b0;
        rst_w = 1'b1; ss_w = 1'b0; clr_w = 1'b0;
        step(); step();
        RESET = 1'b0; rst_w = 1'b0;
        inv_en = 1'b1;
        total++;
        if (digs !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0 ||
            state_dbg !== 2'd0 || dut.presc !== '0) begin
            bad++;
            $display("FAIL reset_state: digs=%h run=%b wrap=%b st=%0d presc=%0d, required 0000 0 0 0 0",
                     digs, running, wrap, state_dbg, dut.presc);
        end
        model_digs = 16'h0000;
    endtask

    task automatic test_start_count();
        int n;
        logic [15:0] got, e;
        start_stop = 1'b1;
        n = 0;
        while (running !== 1'b1 && n < 10) begin
            step();
            n++;
            if (n == 2) start_stop = 1'b0;
        end
        start_stop = 1'b0;
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL start_latency: running after %0d edges, required 3", n);
        end
        for (int i = 0; i < 16; i++) begin
            model_digs = bcd_inc(model_digs);
            exp_q.push_back(model_digs);
        end
        while (exp_q.size() > 0) begin
            wait_change(DIV + 5, n);
            got = digs;
            e = exp_q.pop_front();
            total++;
            if (got !== e || n !== DIV) begin
                bad++;
                $display("FAIL count_step: digs=%h after %0d edges, required %h after %0d", got, n, e, DIV);
            end
        end
    endtask

    task automatic test_pause_resume();
        int n;
        n = 0;
        while (dut.presc !== 4'd2 && n < 20) begin
            step();
            n++;
        end
        // Event lands while presc==4, so the pausing edge still advances it to 5.
        start_stop = 1'b1;
        step(); step();
        start_stop = 1'b0;
        step();
        total++;
        if (state_dbg !== 2'd2 || dut.presc !== 4'd5 || digs !== model_digs) begin
            bad++;
            $display("FAIL pause_entry: st=%0d presc=%0d digs=%h, required 2 5 %h",
                     state_dbg, dut.presc, digs, model_digs);
        end
        for (int i = 0; i < 50; i++) step();
        total++;
        if (digs !== model_digs || dut.presc !== 4'd5 || running !== 1'b0) begin
            bad++;
            $display("FAIL pause_hold: digs=%h presc=%0d run=%b, required %h 5 0",
                     digs, dut.presc, running, model_digs);
        end
        start_stop = 1'b1;
        n = 0;
        while (running !== 1'b1 && n < 10) begin
            step();
            n++;
            if (n == 2) start_stop = 1'b0;
        end
        start_stop = 1'b0;
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL resume_latency: running after %0d edges, required 3", n);
        end
        model_digs = bcd_inc(model_digs);
        exp_q.push_back(model_digs);
        wait_change(20, n);
        total++;
        if (digs !== exp_q.pop_front() || n !== 5) begin
            bad++;
            $display("FAIL resume_phase: digs=%h after %0d edges, required %h after 5", digs, n, model_digs);
        end
    endtask

    task automatic test_reset_mid_count();
        int n;
        n = 0;
        while (digs !== 16'h0042 && n < 400) begin
            step();
            n++;
        end
        total++;
        if (digs !== 16'h0042) begin
            bad++;
            $display("FAIL reach_0042: digs=%h, required 0042", digs);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        total++;
        if (digs !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid: digs=%h run=%b wrap=%b st=%0d, required 0000 0 0 0",
                     digs, running, wrap, state_dbg);
        end
        for (int i = 0; i < 30; i++) step();
        total++;
        if (digs !== 16'h0000 || state_dbg !== 2'd0 || dut.presc !== '0) begin
            bad++;
            $display("FAIL reset_idle_hold: digs=%h st=%0d presc=%0d, required 0000 0 0",
                     digs, state_dbg, dut.presc);
        end
    endtask

    task automatic test_clear_priority();
        start_stop = 1'b1;
        step(); step();
        start_stop = 1'b0;
        for (int i = 0; i < 26; i++) step();
        total++;
        if (running !== 1'b1 || digs !== 16'h0002) begin
            bad++;
            $display("FAIL clr_setup: run=%b digs=%h, required 1 0002", running, digs);
        end
        start_stop = 1'b1;
        clear = 1'b1;
        step(); step();
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL clr_early: run=%b two edges after press, required 1", running);
        end
        step();
        total++;
        if (state_dbg !== 2'd0 || digs !== 16'h0000 || dut.presc !== '0 || running !== 1'b0) begin
            bad++;
            $display("FAIL clr_priority: st=%0d digs=%h presc=%0d run=%b, required 0 0000 0 0",
                     state_dbg, digs, dut.presc, running);
        end
        start_stop = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 10; i++) step();
        total++;
        if (state_dbg !== 2'd0 || digs !== 16'h0000) begin
            bad++;
            $display("FAIL clr_stays_idle: st=%0d digs=%h, required 0 0000", state_dbg, digs);
        end
    endtask

    task automatic test_held_button();
        int trans;
        logic [1:0] prev;
        trans = 0;
        prev = state_dbg;
        start_stop = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (state_dbg !== prev) trans++;
            prev = state_dbg;
        end
        total++;
        if (trans !== 1 || state_dbg !== 2'd1) begin
            bad++;
            $display("FAIL held_once: %0d transitions ending in st=%0d, required 1 ending in 1",
                     trans, state_dbg);
        end
        start_stop = 1'b0;
        for (int i = 0; i < 5; i++) step();
        start_stop = 1'b1;
        for (int i = 0; i < 5; i++) step();
        start_stop = 1'b0;
        total++;
        if (state_dbg !== 2'd2 || running !== 1'b0) begin
            bad++;
            $display("FAIL repress_pause: st=%0d run=%b, required 2 0", state_dbg, running);
        end
    endtask

    task automatic test_wrap();
        int n;
        ss_w = 1'b1;
        step(); step();
        ss_w = 1'b0;
        n = 0;
        while (digs_w !== 16'h9998 && n < 21000) begin
            step();
            n++;
        end
        total++;
        if (digs_w !== 16'h9998 || wrap_w !== 1'b0) begin
            bad++;
            $display("FAIL reach_9998: digs=%h wrap=%b, required 9998 0", digs_w, wrap_w);
        end
        exp_q.push_back(16'h9999);
        exp_q.push_back(16'h0000);
        step(); step();
        total++;
        if (digs_w !== exp_q.pop_front() || wrap_w !== 1'b0) begin
            bad++;
            $display("FAIL tick_9999: digs=%h wrap=%b, required 9999 0", digs_w, wrap_w);
        end
        step();
        total++;
        if (digs_w !== 16'h9999 || wrap_w !== 1'b0) begin
            bad++;
            $display("FAIL hold_9999: digs=%h wrap=%b, required 9999 0", digs_w, wrap_w);
        end
        step();
        total++;
        if (digs_w !== exp_q.pop_front() || wrap_w !== 1'b1 || running_w !== 1'b1) begin
            bad++;
            $display("FAIL rollover: digs=%h wrap=%b run=%b, required 0000 1 1", digs_w, wrap_w, running_w);
        end
        step();
        total++;
        if (wrap_w !== 1'b0 || running_w !== 1'b1 || digs_w !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_one_cycle: wrap=%b run=%b digs=%h, required 0 1 0000", wrap_w, running_w, digs_w);
        end
        step(); step();
        total++;
        if (digs_w !== 16'h0001 || wrap_w !== 1'b0) begin
            bad++;
            $display("FAIL after_wrap: digs=%h wrap=%b, required 0001 0", digs_w, wrap_w);
        end
    endtask

    initial begin
        test_reset();
        test_start_count();
        test_pause_resume();
        test_reset_mid_count();
        test_clear_priority();
        test_held_button();
        test_wrap();
        inv_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
Four-digit BCD stopwatch counter that feeds the dec_to_hex decoders driving HEX0..HEX3. A prescaler derives a counting tick from the board clock. A start/stop button and a clear button drive a small run-control state machine. The block outputs four BCD digits, one per display, with dig0 as the least significant digit.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz.
TICK_HZ, 100, count rate in Hz (the default gives hundredths of a second). DIV = CLK_HZ/TICK_HZ must be >= 2; elaboration error otherwise.

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge.
RESET  input  1  synchronous, active-high reset.
start_stop  input  1  level button, active-high (top level inverts KEY); asynchronous to CLOCK_50.
clear  input  1  level button, active-high; asynchronous to CLOCK_50.
dig0  output  4  BCD units digit, to dec_to_hex for HEX0.
dig1  output  4  BCD tens digit, to HEX1.
dig2  output  4  BCD hundreds digit, to HEX2.
dig3  output  4  BCD thousands digit, to HEX3.
running  output  1  high while state is RUN.
wrap  output  1  one-cycle pulse on the 9999->0000 rollover.

Behaviour:
- Reset (RESET=1 at an edge, including mid-count):
  - dig0..dig3 = 0, state = IDLE, running = 0, wrap = 0.
  - Prescaler = 0; synchronizer and edge flops = 0.
  - Takes effect at the next edge and overrides all other inputs.
- Input conditioning, applied to each of start_stop and clear:
  - Two-flop synchronizer, then a third flop.
  - Event = sync2 & ~sync3, a one-cycle pulse per rising edge.
  - Event is asserted 3 edges after the input rises.
  - A held button gives exactly one event; no debounce in this block.
- States are IDLE, RUN, PAUSE.
  - IDLE: digits 0, prescaler 0, no counting. ss_evt -> RUN.
  - RUN: counting. ss_evt -> PAUSE.
  - PAUSE: digits and prescaler frozen. ss_evt -> RUN; resumes with the prescaler phase retained.
  - clr_evt in any state -> IDLE; digits and prescaler cleared at the same edge.
  - clr_evt and ss_evt on the same cycle: clear wins and the state goes to IDLE.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - tick = (state==RUN && presc==DIV-1); at that edge presc returns to 0.
  - First digit increment occurs DIV edges after the state becomes RUN from IDLE.
- BCD cascade:
  - On tick, dig0 increments.
  - A digit at 9 with carry-in goes to 0 and generates carry-out to the next digit.
  - dig1 increments only when dig0==9 and tick; dig2 and dig3 follow the same rule.
  - Digits update at the same edge as the tick, so output latency from tick is 0 cycles (registered outputs).
- Wrap:
  - 9999 + tick -> 0000, wrap=1 for exactly that one cycle, state stays RUN.
  - wrap=0 at all other times.
- running is decoded from the state register: 1 iff state==RUN.
- Invariant: every digit is <= 9 at all times; the bench asserts this every cycle.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - BCD_W=4, N_DIGITS=4, BCD_MAX=4'd9.
- Sub-module bcd_digit, instantiated 4 times and chained carry_out -> carry_in:
  - Inputs: CLOCK_50, RESET, clr, inc.
  - Outputs: q[3:0], carry_out = inc & (q==9).
- Top: synchronizers, edge detect, FSM, prescaler, wrap = AND of all carry_outs.

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10):
- Reset mid-count: reach 0042, assert RESET for 1 cycle -> next edge digits 0000, running=0, wrap=0; state stays IDLE with no further change.
- Start and count: pulse start_stop for 2 cycles -> running=1 three edges after the rise; dig0=1 exactly 10 edges after running rises; 0 -> 9 -> 10 gives dig1=1, dig0=0.
- Pause/resume: pause at presc=4, hold 50 cycles -> digits and presc frozen; resume -> next increment after 5 edges.
- Wrap: force-run to 9998 (preload via hierarchical deposit), 2 ticks -> 9999 then 0000 with wrap=1 for one cycle; running stays 1.
- Clear priority: ss_evt and clr_evt on the same cycle while in RUN -> state IDLE, digits 0000, presc 0.
- Held button: start_stop held high 1000 cycles -> exactly one transition (IDLE -> RUN); release and re-press -> PAUSE.
